memory_access_controller: RTL and testbench

Sequential, parametrised load/store controller sitting between the decode/execute stage and the data memory port of the 32-bit processor. Accepts one LDR (op 4'b1101) or STR (op 4'b1110) command per start pulse, drives the memory address/data buses through a request/ready handshake with arbitrary wait states, and returns load data with a done pulse. Replaces the combinational select-only controller with a registered, multi-cycle, width-generic unit with error reporting.

---
 rtl/memory_access_controller_if.sv | 35 +++
 rtl/memory_access_controller.sv | 123 ++++++++++++
 tb/tb_memory_access_controller.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/memory_access_controller_if.sv
// Command, status and memory-port bundle for memory_access_controller.
// The slave modport is the controller; the master modport is the command issuer and memory model.
interface memory_access_controller_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              start;
    logic [3:0]        op_code;
    logic [ADDR_W-1:0] source_address;
    logic [DATA_W-1:0] source_data;
    logic              busy;
    logic              done;
    logic              err;
    logic              ldr_sel;
    logic              add_bus_sel;
    logic [ADDR_W-1:0] destination_address;
    logic [DATA_W-1:0] data_bus;
    logic              mem_req;
    logic              mem_we;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] load_data;

    modport master (
        output start, op_code, source_address, source_data, mem_ready, mem_rdata,
        input  busy, done, err, ldr_sel, add_bus_sel, destination_address,
               data_bus, mem_req, mem_we, load_data
    );

    modport slave (
        input  start, op_code, source_address, source_data, mem_ready, mem_rdata,
        output busy, done, err, ldr_sel, add_bus_sel, destination_address,
               data_bus, mem_req, mem_we, load_data
    );
endinterface

// File: rtl/memory_access_controller.sv
// LDR/STR controller: start->done in 2 cycles minimum, +1 per low mem_ready edge; start ignored while busy.
// Optional MEM_CTRL_TIMEOUT_EN bounds the wait on mem_ready to TIMEOUT_CYCLES edges and reports err.
module memory_access_controller #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic                      clk,
    input logic                      reset,
    memory_access_controller_if.slave bus
);
    localparam logic [3:0] OP_LDR = 4'b1101;
    localparam logic [3:0] OP_STR = 4'b1110;

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t            state;
    logic              busy;
    logic              done;
    logic              err;
    logic              ldr_sel;
    logic              add_bus_sel;
    logic [ADDR_W-1:0] destination_address;
    logic [DATA_W-1:0] data_bus;
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] load_data;

    // The terminal count must fit the 8-bit wait counter.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_cycles_out_of_range
    end

`ifdef MEM_CTRL_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wait_cnt;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state               <= IDLE;
            busy                <= 1'b0;
            done                <= 1'b0;
            err                 <= 1'b0;
            ldr_sel             <= 1'b0;
            add_bus_sel         <= 1'b0;
            destination_address <= '0;
            data_bus            <= '0;
            mem_req             <= 1'b0;
            mem_we              <= 1'b0;
            load_data           <= '0;
`ifdef MEM_CTRL_TIMEOUT_EN
            wait_cnt            <= '0;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.op_code == OP_LDR || bus.op_code == OP_STR) begin
                            state               <= REQ;
                            busy                <= 1'b1;
                            mem_req             <= 1'b1;
                            mem_we              <= (bus.op_code == OP_STR);
                            ldr_sel             <= (bus.op_code == OP_LDR);
                            add_bus_sel         <= 1'b1;
                            destination_address <= bus.source_address;
                            data_bus            <= (bus.op_code == OP_STR) ? bus.source_data : '0;
`ifdef MEM_CTRL_TIMEOUT_EN
                            wait_cnt            <= '0;
`endif
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    // mem_ready takes priority over an expiring timeout on the same edge.
                    if (bus.mem_ready) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (ldr_sel) begin
                            load_data <= bus.mem_rdata;
                        end
                    end
`ifdef MEM_CTRL_TIMEOUT_EN
                    else if (wait_cnt == TIMEOUT_LAST) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        err     <= 1'b1;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
`endif
                end
                DONE: begin
                    state               <= IDLE;
                    busy                <= 1'b0;
                    ldr_sel             <= 1'b0;
                    add_bus_sel         <= 1'b0;
                    destination_address <= '0;
                    data_bus            <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy                = busy;
    assign bus.done                = done;
    assign bus.err                 = err;
    assign bus.ldr_sel             = ldr_sel;
    assign bus.add_bus_sel         = add_bus_sel;
    assign bus.destination_address = destination_address;
    assign bus.data_bus            = data_bus;
    assign bus.mem_req             = mem_req;
    assign bus.mem_we              = mem_we;
    assign bus.load_data           = load_data;
endmodule

// File: tb/tb_memory_access_controller.sv
// Directed and randomized LDR/STR/illegal commands checked cycle by cycle against a transaction-level model.
// Timeout scenarios run only when MEM_CTRL_TIMEOUT_EN is defined.
module tb_memory_access_controller;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int TO     = 4;
    localparam logic [3:0] OP_LDR = 4'b1101;
    localparam logic [3:0] OP_STR = 4'b1110;

    logic clk = 1'b0;
    logic reset;

    memory_access_controller_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    memory_access_controller #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    logic [DATA_W-1:0] model_load;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_state(input string tag, input bit e_busy, input bit e_done, input bit e_err,
                                input bit e_ldr, input bit e_add, input logic [ADDR_W-1:0] e_addr,
                                input logic [DATA_W-1:0] e_dbus, input bit e_req, input bit e_we);
        chk({tag, ".busy"},        32'(bus.busy),        32'(e_busy));
        chk({tag, ".done"},        32'(bus.done),        32'(e_done));
        chk({tag, ".err"},         32'(bus.err),         32'(e_err));
        chk({tag, ".ldr_sel"},     32'(bus.ldr_sel),     32'(e_ldr));
        chk({tag, ".add_bus_sel"}, 32'(bus.add_bus_sel), 32'(e_add));
        chk({tag, ".dest_addr"},   bus.destination_address, e_addr);
        chk({tag, ".data_bus"},    bus.data_bus,         e_dbus);
        chk({tag, ".mem_req"},     32'(bus.mem_req),     32'(e_req));
        chk({tag, ".mem_we"},      32'(bus.mem_we),      32'(e_we));
        chk({tag, ".load_data"},   bus.load_data,        model_load);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_idle(input string tag);
        expect_state(tag, 0, 0, 0, 0, 0, '0, '0, 0, 0);
    endtask

    // One command from IDLE; waits = number of low mem_ready edges spent in REQ.
    // poke drives extra starts while busy, which must have no effect.
    task automatic do_cmd(input string tag, input logic [3:0] op, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input int waits,
                          input logic [DATA_W-1:0] rd, input bit poke);
        bit legal;
        bit is_ldr;
        bit is_str;
        logic [DATA_W-1:0] e_dbus;
        is_ldr = (op == OP_LDR);
        is_str = (op == OP_STR);
        legal  = is_ldr || is_str;
        e_dbus = is_str ? d : '0;

        bus.start          = 1'b1;
        bus.op_code        = op;
        bus.source_address = a;
        bus.source_data    = d;
        bus.mem_ready      = 1'b0;
        bus.mem_rdata      = $urandom;
        step();
        bus.start          = 1'b0;
        bus.op_code        = 4'($urandom);
        bus.source_address = $urandom;
        bus.source_data    = $urandom;

        if (!legal) begin
            expect_state({tag, ".illegal"}, 0, 0, 1, 0, 0, '0, '0, 0, 0);
            step();
            expect_idle({tag, ".illegal_after"});
            return;
        end

        expect_state({tag, ".req"}, 1, 0, 0, is_ldr, 1, a, e_dbus, 1, is_str);
        for (int w = 0; w < waits; w++) begin
            bus.start   = poke;
            bus.op_code = poke ? ((w % 2 == 0) ? OP_STR : OP_LDR) : 4'b0000;
            step();
            expect_state({tag, ".req_wait"}, 1, 0, 0, is_ldr, 1, a, e_dbus, 1, is_str);
        end

        bus.start     = 1'b0;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = rd;
        step();
        if (is_ldr) model_load = rd;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = $urandom;
        expect_state({tag, ".done"}, 1, 1, 0, is_ldr, 1, a, e_dbus, 0, 0);

        bus.start   = poke;
        bus.op_code = OP_LDR;
        step();
        bus.start = 1'b0;
        expect_idle({tag, ".idle_after"});
    endtask

    initial begin
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;
        logic [3:0]        rop;

        reset              = 1'b1;
        bus.start          = 1'b0;
        bus.op_code        = 4'b0000;
        bus.source_address = '0;
        bus.source_data    = '0;
        bus.mem_ready      = 1'b0;
        bus.mem_rdata      = '0;
        model_load         = '0;

        step();
        expect_idle("in_reset");
        step();
        reset = 1'b0;
        step();
        expect_idle("after_reset");

        do_cmd("ldr_zero", OP_LDR, 32'h0000_0000, 32'h1234_5678, 0, 32'hFFFF_FFFF, 1'b0);
        do_cmd("str_max", OP_STR, 32'hFFFF_FFFF, 32'hA5A5_A5A5, 3, 32'h0BAD_F00D, 1'b0);
        do_cmd("illegal_0011", 4'b0011, 32'h0000_1000, 32'h5555_5555, 0, 32'h0, 1'b0);
        do_cmd("ldr_ignore_start", OP_LDR, 32'h8000_0004, 32'h0, 2, 32'hC0FF_EE01, 1'b1);

        // Reset in the middle of an STR stuck in REQ.
        bus.start          = 1'b1;
        bus.op_code        = OP_STR;
        bus.source_address = 32'h0000_0040;
        bus.source_data    = 32'hDEAD_BEEF;
        bus.mem_ready      = 1'b0;
        step();
        bus.start = 1'b0;
        expect_state("rst_pre", 1, 0, 0, 0, 1, 32'h0000_0040, 32'hDEAD_BEEF, 1, 1);
        step();
        reset = 1'b1;
        model_load = '0;
        #1;
        expect_idle("rst_async");
        step();
        reset = 1'b0;
        step();
        expect_idle("rst_release");
        step();
        expect_idle("rst_hold_idle");

`ifdef MEM_CTRL_TIMEOUT_EN
        do_cmd("to_seed", OP_LDR, 32'h0000_0100, 32'h0, 0, 32'h1357_9BDF, 1'b0);
        bus.start          = 1'b1;
        bus.op_code        = OP_LDR;
        bus.source_address = 32'h0000_0200;
        bus.mem_ready      = 1'b0;
        bus.mem_rdata      = 32'hFFFF_0000;
        step();
        bus.start = 1'b0;
        expect_state("to_req", 1, 0, 0, 1, 1, 32'h0000_0200, '0, 1, 0);
        for (int i = 0; i < TO - 1; i++) begin
            step();
            expect_state("to_wait", 1, 0, 0, 1, 1, 32'h0000_0200, '0, 1, 0);
        end
        step();
        expect_state("to_expire", 1, 1, 1, 1, 1, 32'h0000_0200, '0, 0, 0);
        step();
        expect_idle("to_idle");
        do_cmd("to_ready_wins", OP_LDR, 32'h0000_0300, 32'h0, TO - 1, 32'h2468_ACE0, 1'b0);
`endif

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0, 1:    rop = OP_LDR;
                2:       rop = OP_STR;
                default: rop = 4'($urandom);
            endcase
            ra = $urandom;
            rd = $urandom;
            do_cmd("rand", rop, ra, rd, int'($urandom_range(0, 3)), 32'($urandom), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
